// File: rtl/spi_slave_responder.sv
// spi_slave_responder: oversampled CPOL=0/CPHA=1 SPI target that shifts out handshaked tx words and deserialises MOSI.
// Optional SPI_SLAVE_ECHO_EN: an empty holding register at word start echoes the last rx_data instead of zeros.
module spi_slave_responder #(
  parameter int WORD_BITS       = 24,
  parameter int WORDS_PER_FRAME = 5
) (
  input  logic                 system_clock,
  input  logic                 reset,
  input  logic                 SPI_CS,
  input  logic                 SPI_SCLK,
  input  logic                 SPI_MOSI,
  output logic                 SPI_MISO,
  input  logic [WORD_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [WORD_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_done,
  output logic                 frame_err,
  output logic                 tx_underrun,
  output logic [7:0]           word_count
);
  localparam int CW = $clog2(WORD_BITS + 1);
  typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE} state_t;
  state_t               state;
  logic [2:0]           cs_s, sclk_s;
  logic [1:0]           mosi_s;
  logic [CW-1:0]        bit_cnt;
  logic [WORD_BITS-1:0] hold, tx_shift, rx_shift, rx_next, fill, word;
  logic                 hold_full, rx_pend;
  logic                 cs_rise, cs_fall, sclk_rise, sclk_fall;
  assign tx_ready = ~hold_full;
  always_comb begin
    cs_rise   = cs_s[1] & ~cs_s[2];
    cs_fall   = ~cs_s[1] & cs_s[2];
    sclk_rise = sclk_s[1] & ~sclk_s[2];
    sclk_fall = ~sclk_s[1] & sclk_s[2];
    rx_next   = {rx_shift[WORD_BITS-2:0], mosi_s[1]};
`ifdef SPI_SLAVE_ECHO_EN
    fill      = rx_data;
`else
    fill      = '0;
`endif
    word      = hold_full ? hold : fill;
  end
  // Synchronisers reset low so WAIT_IDLE only leaves once CS is genuinely seen high.
  always_ff @(posedge system_clock) begin
    if (reset) begin
      cs_s        <= '0;
      sclk_s      <= '0;
      mosi_s      <= '0;
      state       <= WAIT_IDLE;
      bit_cnt     <= '0;
      hold        <= '0;
      hold_full   <= 1'b0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      rx_pend     <= 1'b0;
      SPI_MISO    <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      tx_underrun <= 1'b0;
      word_count  <= '0;
    end else begin
      cs_s       <= {cs_s[1:0], SPI_CS};
      sclk_s     <= {sclk_s[1:0], SPI_SCLK};
      mosi_s     <= {mosi_s[0], SPI_MOSI};
      rx_valid   <= rx_pend;
      rx_pend    <= 1'b0;
      frame_done <= 1'b0;
      if (tx_valid && !hold_full) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end
      case (state)
        WAIT_IDLE: if (cs_s[1]) state <= IDLE;
        IDLE: begin
          SPI_MISO <= 1'b0;
          if (cs_fall) begin
            bit_cnt    <= '0;
            word_count <= '0;
            state      <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            frame_done <= 1'b1;
            frame_err  <= (bit_cnt != '0) || (word_count != 8'(WORDS_PER_FRAME));
            SPI_MISO   <= 1'b0;
            state      <= IDLE;
          end else if (sclk_rise) begin
            if (bit_cnt == '0) begin
              SPI_MISO <= word[WORD_BITS-1];
              tx_shift <= word << 1;
              if (hold_full) hold_full <= 1'b0;
`ifndef SPI_SLAVE_ECHO_EN
              if (!hold_full) tx_underrun <= 1'b1;
`endif
            end else begin
              SPI_MISO <= tx_shift[WORD_BITS-1];
              tx_shift <= tx_shift << 1;
            end
          end else if (sclk_fall) begin
            rx_shift <= rx_next;
            if (bit_cnt == CW'(WORD_BITS - 1)) begin
              rx_data    <= rx_next;
              rx_pend    <= 1'b1;
              bit_cnt    <= '0;
              word_count <= (word_count == 8'hFF) ? word_count : word_count + 8'd1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_slave_responder.sv
// tb_spi_slave_responder: table vectors, directed corner sequences and random frames against a word-level model.
module tb_spi_slave_responder;
  logic        system_clock = 1'b0;
  logic        reset = 1'b1;
  logic        SPI_CS = 1'b1, SPI_SCLK = 1'b0, SPI_MOSI = 1'b0;
  logic        SPI_MISO;
  logic [23:0] tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [23:0] rx_data;
  logic        rx_valid, frame_done, frame_err, tx_underrun;
  logic [7:0]  word_count;

  spi_slave_responder #(.WORD_BITS(24), .WORDS_PER_FRAME(5)) dut (
    .system_clock(system_clock), .reset(reset), .SPI_CS(SPI_CS), .SPI_SCLK(SPI_SCLK),
    .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .frame_done(frame_done),
    .frame_err(frame_err), .tx_underrun(tx_underrun), .word_count(word_count)
  );

  always #5 system_clock = ~system_clock;

  int total = 0, bad = 0;
  int rx_cnt = 0, fd_cnt = 0;
  logic fe_last = 1'b0;
  logic [23:0] rx_got[$], got_miso[$], mosi_q[$], tx_q[$];
  logic        m_underrun = 1'b0;
  logic [23:0] m_last_rx = '0;

  always @(negedge system_clock) begin
    if (rx_valid) begin
      rx_got.push_back(rx_data);
      rx_cnt++;
    end
    if (frame_done) begin
      fd_cnt++;
      fe_last = frame_err;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge system_clock);
    reset = 1'b1; SPI_CS = 1'b1; SPI_SCLK = 1'b0; SPI_MOSI = 1'b0; tx_valid = 1'b0;
    repeat (3) @(negedge system_clock);
    reset = 1'b0;
    m_underrun = 1'b0;
    m_last_rx = '0;
  endtask

  task automatic push_tx(input logic [23:0] w);
    int n = 0;
    @(negedge system_clock);
    while (!tx_ready && n < 2000) begin
      @(negedge system_clock);
      n++;
    end
    if (!tx_ready) begin
      total++; bad++;
      $display("FAIL push_tx timeout word %h", w);
    end else begin
      tx_data = w; tx_valid = 1'b1;
      @(posedge system_clock);
      #1 tx_valid = 1'b0;
    end
  endtask

  task automatic send_bit(input logic m, output logic s);
    SPI_MOSI = m; SPI_SCLK = 1'b1;
    repeat (7) @(negedge system_clock);
    s = SPI_MISO; SPI_SCLK = 1'b0;
    repeat (7) @(negedge system_clock);
  endtask

  task automatic run_frame(input int nbits);
    logic [23:0] acc = '0, w;
    logic s;
    rx_got.delete();
    got_miso.delete();
    if (tx_q.size() > 0) push_tx(tx_q[0]);
    @(negedge system_clock);
    SPI_CS = 1'b0;
    repeat (8) @(negedge system_clock);
    fork
      for (int b = 0; b < nbits; b++) begin
        w = mosi_q[b / 24];
        send_bit(w[23 - (b % 24)], s);
        acc = {acc[22:0], s};
        if (b % 24 == 23) begin
          got_miso.push_back(acc);
          acc = '0;
        end
      end
      for (int k = 1; k < tx_q.size(); k++) push_tx(tx_q[k]);
    join
    if (nbits % 24 != 0) got_miso.push_back(acc);
    repeat (2) @(negedge system_clock);
    SPI_CS = 1'b1;
    repeat (10) @(negedge system_clock);
  endtask

  // Word-level model: each started word consumes one queued tx word, else zeros (or echo).
  task automatic check_frame(input string nm, input int nbits);
    int started = (nbits + 23) / 24, full = nbits / 24, part = nbits % 24, fd0 = fd_cnt;
    logic [23:0] em[$], er[$], t;
    for (int w = 0; w < started; w++) begin
      if (w < tx_q.size()) t = tx_q[w];
      else begin
`ifdef SPI_SLAVE_ECHO_EN
        t = m_last_rx;
`else
        t = '0;
        m_underrun = 1'b1;
`endif
      end
      if (w < full) begin
        em.push_back(t);
        er.push_back(mosi_q[w]);
        m_last_rx = mosi_q[w];
      end else em.push_back(t >> (24 - part));
    end
    run_frame(nbits);
    chk({nm, " rx count"}, rx_got.size(), er.size());
    for (int i = 0; i < er.size() && i < rx_got.size(); i++) chk({nm, " rx word"}, rx_got[i], er[i]);
    chk({nm, " miso count"}, got_miso.size(), em.size());
    for (int i = 0; i < em.size() && i < got_miso.size(); i++) chk({nm, " miso word"}, got_miso[i], em[i]);
    chk({nm, " word_count"}, word_count, (full > 255) ? 255 : full);
    chk({nm, " frame_done"}, fd_cnt - fd0, 1);
    chk({nm, " frame_err"}, fe_last, (part != 0 || full != 5) ? 1 : 0);
    chk({nm, " tx_underrun"}, tx_underrun, m_underrun);
    chk({nm, " miso idle"}, SPI_MISO, 0);
    chk({nm, " tx_ready"}, tx_ready, 1);
  endtask

  typedef struct {
    logic [23:0] mosi, tx;
    int          nbits, exp_rxn;
    logic [23:0] exp_rx, exp_miso;
    logic        exp_err;
  } vec_t;
  vec_t tbl[4];

  initial begin
    int rx0, fd0, full, part, started, ntx;
    logic s;
    tbl[0] = '{24'hA5C3F0, 24'h123456, 24, 1, 24'hA5C3F0, 24'h123456, 1'b1};
    tbl[1] = '{24'h000001, 24'h800000, 24, 1, 24'h000001, 24'h800000, 1'b1};
    tbl[2] = '{24'hFFFFFF, 24'hFFFFFF, 24, 1, 24'hFFFFFF, 24'hFFFFFF, 1'b1};
    tbl[3] = '{24'h5A5A5A, 24'hC00001, 10, 0, 24'h000000, 24'h000300, 1'b1};

    do_reset();
    chk("rst miso", SPI_MISO, 0);
    chk("rst tx_ready", tx_ready, 1);
    chk("rst rx_data", rx_data, 0);
    chk("rst rx_valid", rx_valid, 0);
    chk("rst frame_done", frame_done, 0);
    chk("rst frame_err", frame_err, 0);
    chk("rst tx_underrun", tx_underrun, 0);
    chk("rst word_count", word_count, 0);
    repeat (6) @(negedge system_clock);

    mosi_q = '{24'hA5C3F0}; tx_q = {};
    check_frame("first word", 24);
    mosi_q = '{24'h0F1E2D, 24'h778899}; tx_q = {};
    check_frame("underrun/echo", 48);
    mosi_q = '{24'h13579B}; tx_q = '{24'h2468AC};
    check_frame("sticky", 24);

    do_reset();
    repeat (6) @(negedge system_clock);
    foreach (tbl[i]) begin
      fd0 = fd_cnt;
      mosi_q = '{tbl[i].mosi}; tx_q = '{tbl[i].tx};
      run_frame(tbl[i].nbits);
      chk($sformatf("vec%0d rx count", i), rx_got.size(), tbl[i].exp_rxn);
      if (rx_got.size() > 0) chk($sformatf("vec%0d rx", i), rx_got[0], tbl[i].exp_rx);
      chk($sformatf("vec%0d miso", i), got_miso[0], tbl[i].exp_miso);
      chk($sformatf("vec%0d frame_done", i), fd_cnt - fd0, 1);
      chk($sformatf("vec%0d frame_err", i), fe_last, tbl[i].exp_err);
      chk($sformatf("vec%0d word_count", i), word_count, tbl[i].exp_rxn);
    end
    chk("table no underrun", tx_underrun, 0);

    do_reset();
    repeat (6) @(negedge system_clock);
    mosi_q = '{24'h111111, 24'h222222, 24'h333333, 24'h444444, 24'h555555};
    tx_q = '{24'hABCDEF, 24'h012345, 24'hFEDCBA, 24'h00FF00, 24'h800001};
    check_frame("five words", 120);
    mosi_q = '{24'hC0FFEE, 24'hBADBAD};
    tx_q = '{24'h5A5A5A, 24'hFFFFFF};
    check_frame("partial second", 34);

    mosi_q = '{24'h5A5A5A};
    rx0 = rx_cnt; fd0 = fd_cnt;
    @(negedge system_clock);
    SPI_CS = 1'b0;
    repeat (8) @(negedge system_clock);
    for (int b = 0; b < 12; b++) send_bit(mosi_q[0][23 - b], s);
    reset = 1'b1;
    repeat (2) @(negedge system_clock);
    reset = 1'b0;
    m_underrun = 1'b0; m_last_rx = '0;
    for (int b = 12; b < 24; b++) send_bit(mosi_q[0][23 - b], s);
    repeat (2) @(negedge system_clock);
    SPI_CS = 1'b1;
    repeat (10) @(negedge system_clock);
    chk("midreset rx_valid", rx_cnt - rx0, 0);
    chk("midreset frame_done", fd_cnt - fd0, 0);
    chk("midreset word_count", word_count, 0);
    mosi_q = '{24'h3C5AA5}; tx_q = {};
    check_frame("after midreset", 24);

    do_reset();
    repeat (6) @(negedge system_clock);
    for (int it = 0; it < 8; it++) begin
      full = (it == 0) ? 5 : $urandom_range(0, 6);
      part = (it == 0) ? 0 : $urandom_range(0, 23);
      if (full == 0 && part == 0) part = 7;
      started = full + (part != 0 ? 1 : 0);
      ntx = $urandom_range(0, started);
      mosi_q = {}; tx_q = {};
      for (int k = 0; k < started; k++) mosi_q.push_back(24'($urandom));
      for (int k = 0; k < ntx; k++) tx_q.push_back(24'($urandom));
      check_frame($sformatf("rand%0d", it), full * 24 + part);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_slave_responder.md
Name: spi_slave_responder

Overview:
- SPI responder (target side) for the ADC interface. It receives SPI_SCLK/SPI_CS/SPI_MOSI from our SCLK generator and master logic, and drives SPI_MISO.
- Used as an ADS131A0X-style device emulator for loopback and bring-up: it shifts out words supplied by user logic and deserialises MOSI words.
- All SPI inputs are oversampled in the system_clock domain. There is no logic clocked by SPI_SCLK.

Parameters:
- WORD_BITS, 24, bits per SPI word (valid range 8..32).
- WORDS_PER_FRAME, 5, expected words per CS-low frame (status word plus 4 channels). Used only for frame_err.

Ports:
- system_clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- SPI_CS  in  1  chip select, active low, asynchronous to system_clock.
- SPI_SCLK  in  1  serial clock, idles low, asynchronous to system_clock.
- SPI_MOSI  in  1  master-out data.
- SPI_MISO  out  1  slave-out data.
- tx_data  in  WORD_BITS  next word to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  holding register is empty; a word is accepted when tx_valid && tx_ready.
- rx_data  out  WORD_BITS  last complete received word.
- rx_valid  out  1  one-cycle pulse; rx_data is updated.
- frame_done  out  1  one-cycle pulse on CS deassertion.
- frame_err  out  1  valid with frame_done: partial word, or word count != WORDS_PER_FRAME.
- tx_underrun  out  1  sticky; set when a word starts with the holding register empty. Cleared by reset only.
- word_count  out  8  words completed in the current or last frame.

Behaviour:
- Synchronisation: SPI_CS, SPI_SCLK and SPI_MOSI each pass through a 2-flop synchroniser. A third register on CS and SCLK provides edge detection, so an edge is seen 3 cycles after the pin changes.
- SCLK high and low times must each be at least 4 system_clock cycles. The generator's 7-cycle half period meets this.
- Mode is CPOL=0, CPHA=1: MISO changes on SCLK rising edges; MOSI is sampled on SCLK falling edges.
- Reset values: SPI_MISO=0, tx_ready=1, rx_data=0, rx_valid=0, frame_done=0, frame_err=0, tx_underrun=0, word_count=0, state=WAIT_IDLE.
- State WAIT_IDLE: wait for synced CS=1, then go to IDLE. This prevents joining a frame already in progress after a reset asserted mid-transaction.
- State IDLE: SPI_MISO=0. On a synced CS falling edge: clear bit_cnt and word_count, go to ACTIVE.
- State ACTIVE, SCLK rising edge with bit_cnt==0:
  - If the holding register is full, move it into the tx shifter; tx_ready=1 on the next cycle.
  - Otherwise load zeros and set tx_underrun.
  - In both cases SPI_MISO takes the MSB on the same cycle.
- State ACTIVE, other SCLK rising edges: SPI_MISO takes the next bit of the tx shifter, MSB first.
- State ACTIVE, SCLK falling edge: shift the synced MOSI into the rx shifter LSB; bit_cnt+1.
- When bit_cnt reaches WORD_BITS on a falling edge:
  - rx_data takes the assembled word; rx_valid pulses 1 cycle later.
  - bit_cnt returns to 0; word_count+1, saturating at 255.
- CS rising edge in ACTIVE:
  - frame_done pulses one cycle.
  - frame_err = (bit_cnt!=0) || (word_count!=WORDS_PER_FRAME).
  - A partial word is discarded with no rx_valid; SPI_MISO=0; go to IDLE.
  - A tx word already moved into the shifter is consumed even if the word was partial.
- Simultaneous tx_valid and a shifter load: the load takes the old holding word. tx_ready is 0 on that cycle, so the new word is accepted one cycle later.
- tx_data is captured only on an accepted handshake. The holding register keeps its word across frames.
- Reset overrides everything on the same edge. The holding register is emptied.

Optional Feature:
- Macro: SPI_SLAVE_ECHO_EN.
- Defined: when the holding register is empty at a word start, the tx shifter loads the last completed rx_data (echo/loopback) instead of zeros, and tx_underrun is not set.
- Undefined: zeros are sent and tx_underrun is set, as above.

Test Plan:
- Reset with CS high: all outputs at reset values, tx_ready=1. Drop CS, send 24 SCLKs at 7-cycle half period with MOSI=0xA5C3F0: rx_data=0xA5C3F0, exactly one rx_valid, word_count=1.
- Preload tx_data=0x123456, then run a 24-bit frame: the MISO bits sampled on falling edges reconstruct 0x123456 MSB first. On CS high: frame_done=1, frame_err=1 (1 != 5).
- Five-word frame with five tx words preloaded back-to-back via the handshake: five rx_valid pulses, MISO words match in order, frame_done with frame_err=0, tx_underrun=0.
- Raise CS after 10 SCLKs of the second word: no second rx_valid, word_count=1, frame_done with frame_err=1, MISO=0 after CS high.
- No tx word loaded, 24 SCLKs: MISO all 0, tx_underrun=1 and remains 1 over the next frame until reset. With SPI_SLAVE_ECHO_EN defined, the second word echoes the first rx word and tx_underrun stays 0.
- Assert reset during bit 12 of a word with CS held low: state=WAIT_IDLE, no rx_valid for the rest of the frame. After CS high then low, a new 24-bit word is received correctly.
